stage_sequencer: RTL and testbench

Parametrised multi-cycle stage sequencer for the CPU core. It replaces the fixed five-phase stage counter and emits one-cycle stage-enable strobes in the single `clk` domain instead of deriving per-stage clocks. Over the fixed counter it adds:
- per-instruction stage skipping, decided at decode;
- a request/acknowledge handshake with wait states for the memory stage, plus a timeout fault;
- halt/resume at instruction boundaries;
- retired-instruction and cycle counters.

---
 rtl/stage_sequencer_if.sv | 30 +++
 rtl/stage_sequencer.sv | 138 +++++++++++++
 tb/tb_stage_sequencer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/stage_sequencer_if.sv
// Sequencer <-> core signal bundle: stage strobes, memory handshake, halt control and counters.
interface stage_sequencer_if #(
  parameter int STAGES = 5,
  parameter int CNT_W  = 32
);
  localparam int IDX_W = (STAGES > 1) ? $clog2(STAGES) : 1;

  logic              stall;
  logic [STAGES-1:0] skip_mask;
  logic              mem_ack;
  logic              halt_req;
  logic [STAGES-1:0] stage_en;
  logic [IDX_W-1:0]  stage_idx;
  logic              mem_req;
  logic              retire;
  logic              halted;
  logic              fault;
  logic [CNT_W-1:0]  retired_cnt;
  logic [CNT_W-1:0]  cycle_cnt;

  modport master (
    input  stall, skip_mask, mem_ack, halt_req,
    output stage_en, stage_idx, mem_req, retire, halted, fault, retired_cnt, cycle_cnt
  );

  modport slave (
    output stall, skip_mask, mem_ack, halt_req,
    input  stage_en, stage_idx, mem_req, retire, halted, fault, retired_cnt, cycle_cnt
  );
endinterface

// File: rtl/stage_sequencer.sv
// Multi-cycle stage sequencer: one-cycle stage strobes with decode-time skipping,
// memory-stage request/ack with timeout fault, halt at retire, retire/cycle counters.
module stage_sequencer #(
  parameter int STAGES    = 5,
  parameter int DEC_STAGE = 1,
  parameter int MEM_STAGE = 3,
  parameter int TIMEOUT   = 15,
  parameter int CNT_W     = 32
) (
  input logic              clk,
  input logic              rst,
  stage_sequencer_if.master bus
);
  localparam int IDX_W  = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_HALT, ST_FAULT} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cur_q, cur_d;
  logic [STAGES-1:0] skip_q, skip_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  retired_cnt_q, retired_cnt_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;

  logic              strobe, req, last, found;
  logic [STAGES-1:0] mask;
  logic [IDX_W-1:0]  nxt;

  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    skip_d        = skip_q;
    wait_cnt_d    = wait_cnt_q;
    retired_cnt_d = retired_cnt_q;
    cycle_cnt_d   = cycle_cnt_q;
    strobe        = 1'b0;
    req           = 1'b0;
    last          = 1'b0;
    found         = 1'b0;
    nxt           = '0;
    // The decode strobe must see the incoming mask, not the stale latched one.
    mask          = (cur_q == IDX_W'(DEC_STAGE)) ? bus.skip_mask : skip_q;

    unique case (state_q)
      ST_RUN: begin
        cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        if (!bus.stall) begin
          if (cur_q == IDX_W'(MEM_STAGE)) begin
            req = 1'b1;
            if (bus.mem_ack) begin
              strobe = 1'b1;
            end else begin
              state_d    = (TIMEOUT == 1) ? ST_FAULT : ST_WAIT;
              wait_cnt_d = WAIT_W'(1);
            end
          end else begin
            strobe = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        req         = 1'b1;
        if (bus.mem_ack) begin
          strobe  = 1'b1;
          state_d = ST_RUN;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          if (TIMEOUT != 0 && 32'(wait_cnt_d) == 32'(TIMEOUT)) state_d = ST_FAULT;
        end
      end
      ST_HALT: begin
        if (!bus.halt_req) state_d = ST_RUN;
      end
      ST_FAULT: begin
      end
      default: state_d = ST_RUN;
    endcase

    if (strobe) begin
      wait_cnt_d = '0;
      if (cur_q == IDX_W'(DEC_STAGE)) skip_d = bus.skip_mask;
      if (cur_q < IDX_W'(DEC_STAGE)) begin
        nxt   = cur_q + IDX_W'(1);
        found = 1'b1;
      end else begin
        for (int unsigned j = 0; j < STAGES; j++) begin
          if (!found && j > 32'(cur_q) && !mask[j]) begin
            nxt   = IDX_W'(j);
            found = 1'b1;
          end
        end
      end
      if (found) begin
        cur_d = nxt;
      end else begin
        last          = 1'b1;
        cur_d         = '0;
        retired_cnt_d = retired_cnt_q + CNT_W'(1);
        if (bus.halt_req) state_d = ST_HALT;
      end
    end

    if (rst) begin
      strobe = 1'b0;
      req    = 1'b0;
      last   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      cur_q         <= '0;
      skip_q        <= '0;
      wait_cnt_q    <= '0;
      retired_cnt_q <= '0;
      cycle_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      skip_q        <= skip_d;
      wait_cnt_q    <= wait_cnt_d;
      retired_cnt_q <= retired_cnt_d;
      cycle_cnt_q   <= cycle_cnt_d;
    end
  end

  assign bus.stage_en    = strobe ? (STAGES'(1) << cur_q) : '0;
  assign bus.stage_idx   = cur_q;
  assign bus.mem_req     = req;
  assign bus.retire      = last;
  assign bus.halted      = (state_q == ST_HALT);
  assign bus.fault       = (state_q == ST_FAULT);
  assign bus.retired_cnt = retired_cnt_q;
  assign bus.cycle_cnt   = cycle_cnt_q;
endmodule

// File: tb/tb_stage_sequencer.sv
// Randomized bench for stage_sequencer against a plan-queue model of each instruction's stages.
module tb_stage_sequencer;
  localparam int STAGES = 5;
  localparam int DEC    = 1;
  localparam int MEM    = 3;
  localparam int TMO    = 15;
  localparam int CW     = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stage_sequencer_if #(.STAGES(STAGES), .CNT_W(CW)) bus ();

  stage_sequencer #(
    .STAGES(STAGES), .DEC_STAGE(DEC), .MEM_STAGE(MEM), .TIMEOUT(TMO), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, act, exp);
    end
  endtask

  // Model: the remaining stages of the current instruction, head = executing stage.
  int          plan[$];
  int          pend;
  bit          m_halt, m_fault;
  int unsigned m_ret, m_cyc;

  task automatic refill();
    plan.delete();
    for (int i = 0; i <= DEC; i++) plan.push_back(i);
  endtask

  task automatic m_reset();
    refill();
    pend = 0; m_halt = 0; m_fault = 0; m_ret = 0; m_cyc = 0;
  endtask

  task automatic evaluate();
    logic [STAGES-1:0] e_en;
    logic              e_req, e_ret;
    bit                strobe;
    int                s;
    e_en = '0; e_req = 1'b0; e_ret = 1'b0; strobe = 0;
    if (rst) begin
      check_eq("stage_en_rst", 64'(bus.stage_en), 64'(e_en));
      check_eq("mem_req_rst",  64'(bus.mem_req),  64'(e_req));
      check_eq("retire_rst",   64'(bus.retire),   64'(e_ret));
      m_reset();
      return;
    end
    check_eq("stage_idx",   64'(bus.stage_idx),   64'(plan[0]));
    check_eq("halted",      64'(bus.halted),      64'(m_halt));
    check_eq("fault",       64'(bus.fault),       64'(m_fault));
    check_eq("retired_cnt", 64'(bus.retired_cnt), 64'(m_ret % (1 << CW)));
    check_eq("cycle_cnt",   64'(bus.cycle_cnt),   64'(m_cyc % (1 << CW)));

    if (!m_fault && !m_halt) begin
      m_cyc++;
      s = plan[0];
      if (s == MEM) begin
        if (pend > 0 || !bus.stall) begin
          e_req = 1'b1;
          if (bus.mem_ack) strobe = 1;
          else begin
            pend++;
            if (TMO != 0 && pend == TMO) m_fault = 1;
          end
        end
      end else begin
        strobe = !bus.stall;
      end
      if (strobe) begin
        pend = 0;
        e_en = STAGES'(1) << s;
        void'(plan.pop_front());
        if (s == DEC)
          for (int j = DEC + 1; j < STAGES; j++)
            if (!bus.skip_mask[j]) plan.push_back(j);
        if (plan.size() == 0) begin
          e_ret = 1'b1;
          m_ret++;
          refill();
          if (bus.halt_req) m_halt = 1;
        end
      end
    end else if (m_halt && !bus.halt_req) begin
      m_halt = 0;
    end

    check_eq("stage_en", 64'(bus.stage_en), 64'(e_en));
    check_eq("mem_req",  64'(bus.mem_req),  64'(e_req));
    check_eq("retire",   64'(bus.retire),   64'(e_ret));
  endtask

  initial begin
    int                stall_pct, ack_mode, skip_mode, halt_pct, rst_left;
    logic [STAGES-1:0] skip_fix;
    bus.stall = 1'b0; bus.skip_mask = '0; bus.mem_ack = 1'b0; bus.halt_req = 1'b0;
    m_reset();
    for (int p = 0; p < 60; p++) begin
      skip_fix = '0; stall_pct = 0; ack_mode = 0; skip_mode = 0; halt_pct = 0;
      case (p)
        0: ;
        1: begin skip_mode = 1; skip_fix = 5'b01000; end
        2: begin skip_mode = 1; skip_fix = 5'b11100; end
        3: begin ack_mode = 3; stall_pct = 30; end
        4: ack_mode = 2;
        5: halt_pct = 30;
        default: begin
          stall_pct = $urandom_range(50);
          ack_mode  = $urandom_range(3);
          skip_mode = $urandom_range(2);
          skip_fix  = STAGES'($urandom);
          halt_pct  = ($urandom_range(1) == 0) ? 0 : $urandom_range(40);
        end
      endcase
      rst_left = (p == 0 || m_fault || $urandom_range(3) == 0) ? 2 : 0;
      for (int c = 0; c < 60; c++) begin
        @(posedge clk);
        #1;
        if (rst_left > 0) begin
          rst = 1'b1;
          rst_left--;
        end else begin
          rst = (p > 5 && $urandom_range(199) == 0);
        end
        bus.stall = ($urandom_range(99) < stall_pct);
        case (ack_mode)
          0: bus.mem_ack = 1'b1;
          1: bus.mem_ack = ($urandom_range(1) == 0);
          2: bus.mem_ack = 1'b0;
          default: bus.mem_ack = ($urandom_range(99) < 15);
        endcase
        case (skip_mode)
          0: bus.skip_mask = '0;
          1: bus.skip_mask = skip_fix;
          default: bus.skip_mask = STAGES'($urandom);
        endcase
        bus.halt_req = ($urandom_range(99) < halt_pct);
        @(negedge clk);
        evaluate();
      end
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
